// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg: shared widths, FSM state and grant encodings for the SLC-3 memory arbiter
package slc3_mem_pkg;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
   typedef enum logic {GNT_CPU, GNT_LDR} grant_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick between CPU and loader
// Ports: cpu_req, ldr_req (requests), last_grant (previous winner) -> grant (winner; don't-care when idle)
module rr_arb2
   import slc3_mem_pkg::*;
(
   input  logic   cpu_req,
   input  logic   ldr_req,
   input  grant_t last_grant,
   output grant_t grant
);
   // On a tie the requester that did not win last time is picked.
   assign grant = (cpu_req && (!ldr_req || last_grant == GNT_LDR)) ? GNT_CPU : GNT_LDR;
endmodule

// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter: shares one synchronous memory between the CPU port and the loader port
// Ports: Clk/Reset_n; cpu_* and ldr_* request/ack/data ports; mem_* memory primitive port; busy when not IDLE
module slc3_mem_arbiter
   import slc3_mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RD_WAIT = 2
)(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   state_t            state, state_nx;
   grant_t            last_grant, gnt, pick;
   logic              we_q, start, last_cyc;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        cnt;

   rr_arb2 u_arb (
      .cpu_req    (cpu_req),
      .ldr_req    (ldr_req),
      .last_grant (last_grant),
      .grant      (pick)
   );

   assign start = state == IDLE && (cpu_req || ldr_req);
   // Final memory cycle: ACCESS for writes (or single-cycle reads), else the last WAIT cycle.
   assign last_cyc = (state == ACCESS && (we_q || RD_WAIT == 1)) ||
                     (state == WAIT && cnt == 3'(RD_WAIT - 1));

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) state <= IDLE;
      else          state <= state_nx;

   always_comb begin
      state_nx  = state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      cpu_ack   = 1'b0;
      ldr_ack   = 1'b0;
      busy      = state != IDLE;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if (start) state_nx = ACCESS;
      if (state == ACCESS || state == WAIT) begin
         state_nx = last_cyc ? DONE : WAIT;
         mem_en   = 1'b1;
         mem_we   = state == ACCESS && we_q;
      end
      if (state == DONE) begin
         state_nx = IDLE;
         cpu_ack  = gnt == GNT_CPU;
         ldr_ack  = gnt == GNT_LDR;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         last_grant <= GNT_LDR;
         gnt        <= GNT_CPU;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt        <= 3'd1;
         cpu_rdata  <= '0;
         ldr_rdata  <= '0;
      end else begin
         if (start) begin
            gnt        <= pick;
            last_grant <= pick;
            we_q       <= pick == GNT_CPU ? cpu_we    : ldr_we;
            addr_q     <= pick == GNT_CPU ? cpu_addr  : ldr_addr;
            wdata_q    <= pick == GNT_CPU ? cpu_wdata : ldr_wdata;
         end
         // Counts WAIT cycles; primed to 1 whenever WAIT is entered.
         cnt <= state == WAIT ? cnt + 3'd1 : 3'd1;
         if (last_cyc && !we_q && gnt == GNT_CPU) cpu_rdata <= mem_rdata;
         if (last_cyc && !we_q && gnt == GNT_LDR) ldr_rdata <= mem_rdata;
      end
endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// tb_slc3_mem_arbiter: directed plus randomized transaction-level check of the memory arbiter
module tb_slc3_mem_arbiter;
   localparam int RDW = 2;

   logic        Clk = 0, Reset_n = 0;
   logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
   logic [15:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
   logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        cpu_ack, ldr_ack, mem_en, mem_we, busy;
   logic        pl_en = 0;
   logic [15:0] pl_addr = 0, pl_data = 0;

   logic [15:0] mem     [0:65535] = '{default: 16'h0};
   logic [15:0] ref_mem [0:65535] = '{default: 16'h0};
   logic [15:0] exp_cpu = 0, exp_ldr = 0;
   bit          exp_last_ldr = 1;
   int          checks = 0, errors = 0;

   slc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_WAIT(RDW)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 Clk = ~Clk;

   // Synchronous memory primitive with a side port for preloading
   always @(posedge Clk)
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      pl_en = 1; pl_addr = a; pl_data = d; ref_mem[a] = d;
      tick;
      pl_en = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {27'd0, cpu_ack, ldr_ack, mem_en, mem_we, busy}, 0);
      chk({tag, "_maddr"}, mem_addr, 0);
      chk({tag, "_mwdata"}, mem_wdata, 0);
      chk({tag, "_crdata"}, cpu_rdata, 0);
      chk({tag, "_lrdata"}, ldr_rdata, 0);
   endtask

   task automatic do_reset;
      Reset_n = 0;
      #1;
      chk_zero("reset");
      tick;
      tick;
      Reset_n = 1;
      exp_cpu = 0; exp_ldr = 0; exp_last_ldr = 1;
   endtask

   // One transaction from a single requester, started in IDLE (cycle 0)
   task automatic run(input bit ldr, input bit we, input logic [15:0] addr,
                      input logic [15:0] wdata, input bit perturb);
      int ack_cyc = 0, en_n = 0, we_n = 0, bad = 0, other = 0;
      if (ldr) begin ldr_req = 1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; end
      else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
      for (int k = 1; k <= 20 && ack_cyc == 0; k++) begin
         tick;
         if (perturb && k == 2) begin cpu_addr = addr + 1; ldr_addr = addr + 1; end
         en_n += int'(mem_en);
         we_n += int'(mem_we);
         if (mem_en && mem_addr !== addr) bad++;
         if (mem_we && mem_wdata !== wdata) bad++;
         if (ldr ? cpu_ack : ldr_ack) other++;
         if (ldr ? ldr_ack : cpu_ack) begin ack_cyc = k; cpu_req = 0; ldr_req = 0; end
      end
      if (we) ref_mem[addr] = wdata;
      else if (ldr) exp_ldr = ref_mem[addr];
      else exp_cpu = ref_mem[addr];
      exp_last_ldr = ldr;
      chk("ack_cycle", ack_cyc, we ? 2 : RDW + 1);
      chk("en_cycles", en_n, we ? 1 : RDW);
      chk("we_cycles", we_n, {31'd0, we});
      chk("addr_data", bad, 0);
      chk("other_ack", other, 0);
      chk("cpu_rdata", cpu_rdata, exp_cpu);
      chk("ldr_rdata", ldr_rdata, exp_ldr);
      tick;
      chk("idle_after", {30'd0, busy, cpu_ack | ldr_ack}, 0);
   endtask

   // Both requesters read at once; the winner follows the round-robin rule
   task automatic tie(input logic [15:0] ca, input logic [15:0] la);
      int c_cyc = 0, l_cyc = 0, both = 0;
      bit win_ldr = ~exp_last_ldr;
      cpu_req = 1; cpu_we = 0; cpu_addr = ca;
      ldr_req = 1; ldr_we = 0; ldr_addr = la;
      for (int k = 1; k <= 30 && (c_cyc == 0 || l_cyc == 0); k++) begin
         tick;
         if (cpu_ack && ldr_ack) both++;
         if (cpu_ack) begin c_cyc = k; cpu_req = 0; end
         if (ldr_ack) begin l_cyc = k; ldr_req = 0; end
      end
      cpu_req = 0; ldr_req = 0;
      exp_cpu = ref_mem[ca];
      exp_ldr = ref_mem[la];
      exp_last_ldr = ~win_ldr;
      chk("tie_cpu_cycle", c_cyc, win_ldr ? 2 * RDW + 3 : RDW + 1);
      chk("tie_ldr_cycle", l_cyc, win_ldr ? RDW + 1 : 2 * RDW + 3);
      chk("tie_both_ack", both, 0);
      chk("tie_cpu_rdata", cpu_rdata, exp_cpu);
      chk("tie_ldr_rdata", ldr_rdata, exp_ldr);
      tick;
   endtask

   initial begin
      tick;
      preload(16'h3000, 16'h1234);
      preload(16'h3001, 16'h5678);
      for (int i = 0; i < 16; i++) preload(16'h4000 + 16'(i), 16'($urandom));
      do_reset;
      tick;
      run(0, 0, 16'h3000, 0, 0);
      run(1, 1, 16'h0010, 16'hBEEF, 0);
      run(0, 0, 16'h0010, 0, 0);
      do_reset;
      tie(16'h3000, 16'h3001);
      run(0, 0, 16'h3001, 0, 0);
      tie(16'h3001, 16'h3000);
      run(0, 0, 16'h3000, 0, 1);
      run(1, 0, 16'h3001, 0, 1);
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3001;
      tick;
      tick;
      chk("mid_wait_busy", {31'd0, busy}, 1);
      Reset_n = 0;
      #1;
      chk_zero("mid_reset");
      cpu_req = 0;
      tick;
      chk("no_ack_in_reset", {30'd0, cpu_ack, ldr_ack}, 0);
      Reset_n = 1;
      exp_cpu = 0; exp_ldr = 0; exp_last_ldr = 1;
      tick;
      chk("no_ack_after_reset", {30'd0, cpu_ack, ldr_ack}, 0);
      run(0, 0, 16'h3001, 0, 0);
      for (int i = 0; i < 40; i++)
         if ($urandom_range(0, 3) == 0)
            tie(16'h4000 + 16'($urandom_range(0, 15)), 16'h4000 + 16'($urandom_range(0, 15)));
         else
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'h4000 + 16'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
